add_sub_pipe: RTL and testbench



---
 rtl/add_sub_pipe_if.sv | 27 ++
 rtl/add_sub_pipe.sv | 121 ++++++++++++
 tb/tb_add_sub_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/add_sub_pipe_if.sv
// Streaming operand/result bundle for add_sub_pipe: valid/ready on both sides
// plus the operand and flag payloads.
interface add_sub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor split into STAGES carry segments with a
// registered carry between segments; valid/ready on both ends, global stall.
module add_sub_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  add_sub_pipe_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("add_sub_pipe: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  endfunction

  logic             en;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic             cy_p0;
  logic             vld_p0;

  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // p0: accept and condition operands (subtract = add ~b with carry-in 1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0   <= '0;
      b_p0   <= '0;
      cy_p0  <= 1'b0;
      vld_p0 <= 1'b0;
    end else if (en) begin
      vld_p0 <= bus.in_valid;
      a_p0   <= bus.a;
      b_p0   <= bus.sub ? ~bus.b : bus.b;
      cy_p0  <= bus.sub | bus.cin;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits not yet consumed: the skew registers shrink by SEG per stage
    localparam int REM = WIDTH - k * SEG;

    logic [REM-1:0]         a_rem;
    logic [REM-1:0]         b_rem;
    logic                   c_in;
    logic                   v_in;
    logic [SEG:0]           add_res;
    logic [(k+1)*SEG-1:0]   sum_d;
    logic [(k+1)*SEG-1:0]   sum_q;
    logic                   cy_q;
    logic                   vld_q;

    if (k == 0) begin : g_first
      assign a_rem = a_p0;
      assign b_rem = b_p0;
      assign c_in  = cy_p0;
      assign v_in  = vld_p0;
      assign sum_d = add_res[SEG-1:0];
    end else begin : g_next
      assign a_rem = g_stg[k-1].g_pass.a_q;
      assign b_rem = g_stg[k-1].g_pass.b_q;
      assign c_in  = g_stg[k-1].cy_q;
      assign v_in  = g_stg[k-1].vld_q;
      assign sum_d = {add_res[SEG-1:0], g_stg[k-1].sum_q};
    end

    assign add_res = seg_add(a_rem[SEG-1:0], b_rem[SEG-1:0], c_in);

    // p(k+1): segment k result, lower segments deskewed alongside
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        cy_q  <= 1'b0;
        vld_q <= 1'b0;
      end else if (en) begin
        sum_q <= sum_d;
        cy_q  <= add_res[SEG];
        vld_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_pass
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_rem[REM-1:SEG];
          b_q <= b_rem[REM-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // a^b^sum at the MSB recovers the carry into the MSB
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= a_rem[SEG-1] ^ b_rem[SEG-1] ^ add_res[SEG-1] ^ add_res[SEG];
        end
      end
    end
  end

  assign bus.out_valid = g_stg[STAGES-1].vld_q;
  assign bus.sum       = g_stg[STAGES-1].sum_q;
  assign bus.carry     = g_stg[STAGES-1].cy_q;
  assign bus.overflow  = g_stg[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed flag/latency/backpressure/reset steps on an
// (8,2) instance, then random streaming on (8,1), (8,2), (8,8) and (32,4).
module tb_add_sub_pipe;
  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  add_sub_pipe_if #(.WIDTH(8))  bus1 ();
  add_sub_pipe_if #(.WIDTH(8))  bus2 ();
  add_sub_pipe_if #(.WIDTH(8))  bus8 ();
  add_sub_pipe_if #(.WIDTH(32)) bus32 ();

  add_sub_pipe #(.WIDTH(8),  .STAGES(1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  add_sub_pipe #(.WIDTH(8),  .STAGES(2)) dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
  add_sub_pipe #(.WIDTH(8),  .STAGES(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  add_sub_pipe #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [33:0] q0[$];
  logic [33:0] q1[$];
  logic [33:0] q2[$];
  logic [33:0] q3[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (w+1)-bit arithmetic on the operands, flags from sign rules
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [63:0] mask, ea, eb, full;
    logic [31:0] s;
    logic        cy, of;
    mask = (64'd1 << w) - 64'd1;
    ea   = {32'd0, a} & mask;
    eb   = (sb ? ~{32'd0, b} : {32'd0, b}) & mask;
    full = ea + eb + (sb ? 64'd1 : {63'd0, ci});
    s    = full[31:0] & mask[31:0];
    cy   = full[w];
    of   = (ea[w-1] == eb[w-1]) && (s[w-1] != ea[w-1]);
    return {of, cy, s};
  endfunction

  task automatic qpush(input int id, input logic [33:0] e);
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic qpop(input int id, output logic [33:0] e, output logic ok);
    e  = '0;
    ok = 1'b0;
    case (id)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
      default: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic mon(input int id, input int w, input logic acc, input logic ohs,
                     input logic [31:0] s, input logic cy, input logic of,
                     input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
    logic [33:0] e;
    logic        ok;
    if (ohs) begin
      qpop(id, e, ok);
      chk($sformatf("rand%0d_expected_pending", id), ok, 1);
      if (ok) chk($sformatf("rand%0d_result", id), {of, cy, s}, e);
    end
    if (acc) qpush(id, model(w, a, b, ci, sb));
  endtask

  task automatic drive_all(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sb, input logic ordy);
    bus1.in_valid = v;  bus1.a = a[7:0];  bus1.b = b[7:0];  bus1.cin = ci;  bus1.sub = sb;  bus1.out_ready = ordy;
    bus2.in_valid = v;  bus2.a = a[7:0];  bus2.b = b[7:0];  bus2.cin = ci;  bus2.sub = sb;  bus2.out_ready = ordy;
    bus8.in_valid = v;  bus8.a = a[7:0];  bus8.b = b[7:0];  bus8.cin = ci;  bus8.sub = sb;  bus8.out_ready = ordy;
    bus32.in_valid = v; bus32.a = a;      bus32.b = b;      bus32.cin = ci; bus32.sub = sb; bus32.out_ready = ordy;
  endtask

  task automatic set2(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic sb, input logic ordy);
    bus2.in_valid = v; bus2.a = a; bus2.b = b; bus2.cin = ci; bus2.sub = sb; bus2.out_ready = ordy;
  endtask

  // Accept one op, confirm it is not out early, then check it after edge N+2
  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic sb,
                         input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clk);
    set2(1'b1, a, b, ci, sb, 1'b1);
    @(negedge clk);
    set2(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk({tag, "_early"}, bus2.out_valid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, bus2.out_valid, 1);
    chk({tag, "_sum"},   bus2.sum, es);
    chk({tag, "_carry"}, bus2.carry, ec);
    chk({tag, "_ovf"},   bus2.overflow, eo);
  endtask

  initial begin
    int idx, got, cyc, n1, n2, n8, n32;
    logic v, ordy, rc, rs;
    logic [31:0] ra, rb;

    rst_n = 1'b1;
    drive_all(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus2.out_valid, 0);
    chk("rst_sum",       bus2.sum, 0);
    chk("rst_carry",     bus2.carry, 0);
    chk("rst_ovf",       bus2.overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus2.in_ready, 1);

    run_one("add_wrap",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_one("add_ovf",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_one("sub_ovf",   8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_one("sub_borrow",8'h03, 8'h05, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_one("add_cin",   8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);

    // Backpressure: four back-to-back adds, consumer stalls for 3 cycles
    @(negedge clk);
    idx = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (c > 0) @(negedge clk);
      set2(idx < 4, 8'(idx + 1), 8'(idx + 1), 1'b0, 1'b0, !(c >= 3 && c <= 5));
      #1;
      if (c >= 3 && c <= 5) begin
        chk("bp_in_ready",   bus2.in_ready, 0);
        chk("bp_out_valid",  bus2.out_valid, 1);
        chk("bp_sum_stable", bus2.sum, 8'h02);
      end
      if (bus2.out_valid && bus2.out_ready) begin
        chk($sformatf("bp_order%0d", got), bus2.sum, 8'(2 * (got + 1)));
        got++;
      end
      if (bus2.in_valid && bus2.in_ready) idx++;
    end
    chk("bp_count", got, 4);
    @(negedge clk);
    set2(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    chk("bp_no_dup", bus2.out_valid, 0);

    // Reset mid-operation with two results in flight
    @(negedge clk);
    set2(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set2(1'b1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set2(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_pre_valid", bus2.out_valid, 1);
    chk("mid_pre_sum",   bus2.sum, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus2.out_valid, 0);
    chk("mid_rst_sum",   bus2.sum, 0);
    chk("mid_rst_carry", bus2.carry, 0);
    chk("mid_rst_ovf",   bus2.overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    set2(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #1;
    chk("mid_in_ready", bus2.in_ready, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("mid_no_stale%0d", c), bus2.out_valid, 0);
    end

    // Random streaming on all four configurations
    n1 = 0; n2 = 0; n8 = 0; n32 = 0; cyc = 0;
    while ((n1 < 500 || n2 < 500 || n8 < 500 || n32 < 500) && cyc < 8000) begin
      @(negedge clk);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      rs   = 1'($urandom_range(0, 1));
      drive_all(v, ra, rb, rc, rs, ordy);
      #1;
      mon(0, 8,  bus1.in_valid && bus1.in_ready,   bus1.out_valid && bus1.out_ready,
          {24'd0, bus1.sum}, bus1.carry, bus1.overflow, ra, rb, rc, rs);
      mon(1, 8,  bus2.in_valid && bus2.in_ready,   bus2.out_valid && bus2.out_ready,
          {24'd0, bus2.sum}, bus2.carry, bus2.overflow, ra, rb, rc, rs);
      mon(2, 8,  bus8.in_valid && bus8.in_ready,   bus8.out_valid && bus8.out_ready,
          {24'd0, bus8.sum}, bus8.carry, bus8.overflow, ra, rb, rc, rs);
      mon(3, 32, bus32.in_valid && bus32.in_ready, bus32.out_valid && bus32.out_ready,
          bus32.sum, bus32.carry, bus32.overflow, ra, rb, rc, rs);
      if (bus1.in_valid && bus1.in_ready)   n1++;
      if (bus2.in_valid && bus2.in_ready)   n2++;
      if (bus8.in_valid && bus8.in_ready)   n8++;
      if (bus32.in_valid && bus32.in_ready) n32++;
      cyc++;
    end
    chk("rand_budget", (n1 >= 500 && n2 >= 500 && n8 >= 500 && n32 >= 500), 1);

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive_all(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      #1;
      mon(0, 8,  1'b0, bus1.out_valid,  {24'd0, bus1.sum}, bus1.carry, bus1.overflow, 32'd0, 32'd0, 1'b0, 1'b0);
      mon(1, 8,  1'b0, bus2.out_valid,  {24'd0, bus2.sum}, bus2.carry, bus2.overflow, 32'd0, 32'd0, 1'b0, 1'b0);
      mon(2, 8,  1'b0, bus8.out_valid,  {24'd0, bus8.sum}, bus8.carry, bus8.overflow, 32'd0, 32'd0, 1'b0, 1'b0);
      mon(3, 32, 1'b0, bus32.out_valid, bus32.sum, bus32.carry, bus32.overflow, 32'd0, 32'd0, 1'b0, 1'b0);
    end
    chk("rand_drained", q0.size() + q1.size() + q2.size() + q3.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
